// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// Holds the result entry layout, the idle robNum marker and the requester ids.
package cdb_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  // robNum driven on an idle CDB channel
  localparam logic [ROB_W-1:0] INVALID_ROB = 6'b010000;

  localparam int REQ_ALU = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_LD  = 2;
  localparam int REQ_MUL = 3;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO: push/pop/flush with full/empty flags and a
// combinational head entry. Push into a full FIFO and pop from an empty one
// are ignored; flush empties the FIFO and wins over push and pop.
module cdb_req_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  cdb_entry_t i_entry,
  input  logic       i_pop,
  output cdb_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy tracking; flush discards everything pending.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clock) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving two registered common data buses from
// per-requester result FIFOs (0 = ALU, 1 = branch, 2 = load, 3 = mul).
// Up to two FIFOs drain per cycle: the first non-empty one from rr_ptr goes to
// CDB0, the next to CDB1.
// Optional macro CDB_ARB_STATS_EN adds saturating per-requester stall counters
// on output stall_cnt.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb0_valid,
  output logic [ROB_W-1:0]          cdb0_rob,
  output logic [DATA_W-1:0]         cdb0_data,
  output logic                      cdb1_valid,
  output logic [ROB_W-1:0]          cdb1_rob,
  output logic [DATA_W-1:0]         cdb1_data
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stall_cnt
`endif
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RR_W-1:0]   r_rr_ptr;
  logic              r_run;
  logic              r_cdb0_valid;
  logic [ROB_W-1:0]  r_cdb0_rob;
  logic [DATA_W-1:0] r_cdb0_data;
  logic              r_cdb1_valid;
  logic [ROB_W-1:0]  r_cdb1_rob;
  logic [DATA_W-1:0] r_cdb1_data;

  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_push;
  logic [NUM_REQ-1:0] w_pop;
  cdb_entry_t         w_in   [NUM_REQ];
  cdb_entry_t         w_head [NUM_REQ];
  logic               w_g0_vld;
  logic               w_g1_vld;
  logic [RR_W-1:0]    w_g0;
  logic [RR_W-1:0]    w_g1;
  logic [RR_W:0]      w_idx;
  logic [RR_W-1:0]    w_rr_nxt;

  function automatic logic [RR_W-1:0] f_next_idx(input logic [RR_W-1:0] idx);
    if (idx == RR_W'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // req_ready comes only from registered state and stays low until the first
  // edge after reset release.
  assign req_ready = {NUM_REQ{r_run}} & ~w_full;
  assign w_push    = req_valid & req_ready;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    assign w_in[gi] = {req_rob[gi*ROB_W +: ROB_W], req_data[gi*DATA_W +: DATA_W]};

    cdb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_push  (w_push[gi]),
      .i_entry (w_in[gi]),
      .i_pop   (w_pop[gi]),
      .o_head  (w_head[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );
  end

  // Two-grant round-robin scan over non-empty FIFOs starting at rr_ptr.
  always_comb begin
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0     = '0;
    w_g1     = '0;
    w_idx    = '0;
    w_pop    = '0;
    w_rr_nxt = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (RR_W+1)'(k);
      if (w_idx >= (RR_W+1)'(NUM_REQ)) w_idx = w_idx - (RR_W+1)'(NUM_REQ);
      if (!w_empty[w_idx[RR_W-1:0]]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0     = w_idx[RR_W-1:0];
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1     = w_idx[RR_W-1:0];
        end
      end
    end
    if (w_g0_vld) w_pop[w_g0] = 1'b1;
    if (w_g1_vld) w_pop[w_g1] = 1'b1;
    if (w_g1_vld)      w_rr_nxt = f_next_idx(w_g1);
    else if (w_g0_vld) w_rr_nxt = f_next_idx(w_g0);
  end

  // Ready enable: holds req_ready low through reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Registered CDB channels and pointer; flush idles both buses, keeps rr_ptr.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_cdb0_valid <= 1'b0;
      r_cdb0_rob   <= INVALID_ROB;
      r_cdb0_data  <= '0;
      r_cdb1_valid <= 1'b0;
      r_cdb1_rob   <= INVALID_ROB;
      r_cdb1_data  <= '0;
    end else if (flush) begin
      r_cdb0_valid <= 1'b0;
      r_cdb0_rob   <= INVALID_ROB;
      r_cdb1_valid <= 1'b0;
      r_cdb1_rob   <= INVALID_ROB;
    end else begin
      r_rr_ptr     <= w_rr_nxt;
      r_cdb0_valid <= w_g0_vld;
      r_cdb0_rob   <= w_g0_vld ? w_head[w_g0].rob : INVALID_ROB;
      if (w_g0_vld) r_cdb0_data <= w_head[w_g0].data;
      r_cdb1_valid <= w_g1_vld;
      r_cdb1_rob   <= w_g1_vld ? w_head[w_g1].rob : INVALID_ROB;
      if (w_g1_vld) r_cdb1_data <= w_head[w_g1].data;
    end
  end

  assign cdb0_valid = r_cdb0_valid;
  assign cdb0_rob   = r_cdb0_rob;
  assign cdb0_data  = r_cdb0_data;
  assign cdb1_valid = r_cdb1_valid;
  assign cdb1_rob   = r_cdb1_rob;
  assign cdb1_data  = r_cdb1_data;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] r_stall [NUM_REQ];

  // Saturating count of cycles each requester offered a result but was refused.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_stall[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && (r_stall[i] != 16'hFFFF))
          r_stall[i] <= r_stall[i] + 16'd1;
      end
    end
  end

  for (genvar gs = 0; gs < NUM_REQ; gs++) begin : g_stall
    assign stall_cnt[gs*16 +: 16] = r_stall[gs];
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single/dual broadcast, back-to-back,
// flush, asynchronous reset mid-burst and round-robin fairness.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 4;

  logic                 clock = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR*ROB_W-1:0]  req_rob = '0;
  logic [NR*DATA_W-1:0] req_data = '0;
  logic [NR-1:0]        req_ready;
  logic                 cdb0_valid;
  logic [ROB_W-1:0]     cdb0_rob;
  logic [DATA_W-1:0]    cdb0_data;
  logic                 cdb1_valid;
  logic [ROB_W-1:0]     cdb1_rob;
  logic [DATA_W-1:0]    cdb1_data;
`ifdef CDB_ARB_STATS_EN
  logic [NR*16-1:0]     stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(2)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_rob    (req_rob),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .cdb0_valid (cdb0_valid),
    .cdb0_rob   (cdb0_rob),
    .cdb0_data  (cdb0_data),
    .cdb1_valid (cdb1_valid),
    .cdb1_rob   (cdb1_rob),
    .cdb1_data  (cdb1_data)
`ifdef CDB_ARB_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic set_req(input int i, input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] data);
    req_rob[i*ROB_W +: ROB_W]    = rob;
    req_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (cdb0_valid !== 1'b0) begin errors++; $display("FAIL reset_cdb0_valid: got %b expected 0", cdb0_valid); end
    checks++; if (cdb1_valid !== 1'b0) begin errors++; $display("FAIL reset_cdb1_valid: got %b expected 0", cdb1_valid); end
    checks++; if (cdb0_rob !== 6'b010000) begin errors++; $display("FAIL reset_cdb0_rob: got %h expected 10", cdb0_rob); end
    checks++; if (cdb1_rob !== 6'b010000) begin errors++; $display("FAIL reset_cdb1_rob: got %h expected 10", cdb1_rob); end
    checks++; if (cdb0_data !== 32'h0 || cdb1_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", cdb0_data, cdb1_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
`ifdef CDB_ARB_STATS_EN
    checks++; if (stall_cnt !== 64'h0) begin errors++; $display("FAIL reset_stall: got %h expected 0", stall_cnt); end
`endif
    @(negedge clock); rst_n = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL post_reset_ready: got %b expected 1111", req_ready); end
  endtask

  task automatic test_single();
    @(negedge clock); req_valid = 4'b0010; set_req(1, 6'd5, 32'h1234);
    @(negedge clock); req_valid = 4'b0000;
    checks++; if (cdb0_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", cdb0_valid); end
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd5 || cdb0_data !== 32'h1234) begin errors++; $display("FAIL single_cdb0: got v=%b rob=%0d data=%h expected v=1 rob=5 data=1234", cdb0_valid, cdb0_rob, cdb0_data); end
    checks++; if (cdb1_valid !== 1'b0 || cdb1_rob !== 6'b010000) begin errors++; $display("FAIL single_cdb1_idle: got v=%b rob=%h expected v=0 rob=10", cdb1_valid, cdb1_rob); end
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b0 || cdb0_rob !== 6'b010000 || cdb0_data !== 32'h1234) begin errors++; $display("FAIL single_pulse_hold: got v=%b rob=%h data=%h expected v=0 rob=10 data=1234", cdb0_valid, cdb0_rob, cdb0_data); end
    // rr_ptr is now 2; requester 3 alone wraps it back to 0
    @(negedge clock); req_valid = 4'b1000; set_req(3, 6'd7, 32'h77);
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd7 || cdb0_data !== 32'h77 || cdb1_valid !== 1'b0) begin errors++; $display("FAIL single_req3: got v0=%b rob=%0d data=%h v1=%b expected v0=1 rob=7 data=77 v1=0", cdb0_valid, cdb0_rob, cdb0_data, cdb1_valid); end
  endtask

  task automatic test_all_four();
    @(negedge clock);
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_req(i, 6'(i + 1), 32'hA0 + i);
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd1 || cdb0_data !== 32'hA0) begin errors++; $display("FAIL four_t1_cdb0: got v=%b rob=%0d data=%h expected v=1 rob=1 data=a0", cdb0_valid, cdb0_rob, cdb0_data); end
    checks++; if (cdb1_valid !== 1'b1 || cdb1_rob !== 6'd2 || cdb1_data !== 32'hA1) begin errors++; $display("FAIL four_t1_cdb1: got v=%b rob=%0d data=%h expected v=1 rob=2 data=a1", cdb1_valid, cdb1_rob, cdb1_data); end
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd3 || cdb0_data !== 32'hA2) begin errors++; $display("FAIL four_t2_cdb0: got v=%b rob=%0d data=%h expected v=1 rob=3 data=a2", cdb0_valid, cdb0_rob, cdb0_data); end
    checks++; if (cdb1_valid !== 1'b1 || cdb1_rob !== 6'd4 || cdb1_data !== 32'hA3) begin errors++; $display("FAIL four_t2_cdb1: got v=%b rob=%0d data=%h expected v=1 rob=4 data=a3", cdb1_valid, cdb1_rob, cdb1_data); end
    // rr_ptr back at 0: requester 0 must win CDB0 over requester 1
    @(negedge clock); req_valid = 4'b0011; set_req(0, 6'd10, 32'h10); set_req(1, 6'd11, 32'h11);
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd10 || cdb1_valid !== 1'b1 || cdb1_rob !== 6'd11) begin errors++; $display("FAIL four_rr_wrap: got %b/%0d %b/%0d expected 1/10 1/11", cdb0_valid, cdb0_rob, cdb1_valid, cdb1_rob); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        checks++;
        if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'(20 + k - 2) || cdb0_data !== 32'h2000 + 32'(k - 2) || cdb1_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_bcast%0d: got v0=%b rob=%0d data=%h v1=%b expected v0=1 rob=%0d data=%h v1=0", k - 2, cdb0_valid, cdb0_rob, cdb0_data, cdb1_valid, 20 + k - 2, 32'h2000 + 32'(k - 2));
        end
      end
      if (k < 3) begin
        req_valid = 4'b0100; set_req(2, 6'(20 + k), 32'h2000 + 32'(k));
        checks++; if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", k, req_ready[2]); end
      end else begin
        req_valid = 4'b0000;
      end
    end
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", cdb0_valid); end
  endtask

  task automatic test_flush();
    // rr_ptr = 3 on entry
    @(negedge clock);
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_req(i, 6'(30 + i), 32'h3000 + i);
    @(negedge clock);
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL flush_fill_ready: got %b expected 1111", req_ready); end
    req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_req(i, 6'(40 + i), 32'h4000 + i);
    @(negedge clock);
    checks++; if (cdb0_rob !== 6'd33 || cdb1_rob !== 6'd30 || cdb0_valid !== 1'b1 || cdb1_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_grant: got %b/%0d %b/%0d expected 1/33 1/30", cdb0_valid, cdb0_rob, cdb1_valid, cdb1_rob); end
    checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL flush_full_ready: got %b expected 1001", req_ready); end
    flush = 1'b1; req_valid = 4'b0011; set_req(0, 6'd9, 32'h9); set_req(1, 6'd45, 32'h45);
    @(negedge clock);
    flush = 1'b0; req_valid = 4'b0000;
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL flush_ready: got %b expected 1111", req_ready); end
    checks++; if (cdb0_rob !== 6'b010000 || cdb0_data !== 32'h3003 || cdb1_data !== 32'h3000) begin errors++; $display("FAIL flush_idle_fields: got rob=%h d0=%h d1=%h expected rob=10 d0=3003 d1=3000", cdb0_rob, cdb0_data, cdb1_data); end
`ifdef CDB_ARB_STATS_EN
    checks++; if (stall_cnt !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL flush_stall_cnt: got %h expected 0000000000010000", stall_cnt); end
`endif
    for (int k = 0; k < 3; k++) begin
      checks++; if (cdb0_valid !== 1'b0 || cdb1_valid !== 1'b0) begin errors++; $display("FAIL flush_no_bcast%0d: got %b/%b expected 0/0", k, cdb0_valid, cdb1_valid); end
      @(negedge clock);
    end
    // rr_ptr retained at 1: requester 1 first, then 3, then 0
    req_valid = 4'b1011; set_req(0, 6'd50, 32'h50); set_req(1, 6'd51, 32'h51); set_req(3, 6'd53, 32'h53);
    @(negedge clock); req_valid = 4'b0000;
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd51 || cdb1_valid !== 1'b1 || cdb1_rob !== 6'd53) begin errors++; $display("FAIL flush_rr_keep: got %b/%0d %b/%0d expected 1/51 1/53", cdb0_valid, cdb0_rob, cdb1_valid, cdb1_rob); end
    @(negedge clock);
    checks++; if (cdb0_valid !== 1'b1 || cdb0_rob !== 6'd50 || cdb1_valid !== 1'b0) begin errors++; $display("FAIL flush_rr_next: got %b/%0d %b expected 1/50 0", cdb0_valid, cdb0_rob, cdb1_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_req(i, 6'(60 + i), 32'h6000 + i);
    @(negedge clock);
    for (int i = 0; i < NR; i++) set_req(i, 6'(4 + i), 32'h7000 + i);
    @(posedge clock); #2;
    checks++; if (cdb0_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", cdb0_valid); end
    rst_n = 1'b0; #1;
    checks++; if (cdb0_valid !== 1'b0 || cdb1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b/%b expected 0/0", cdb0_valid, cdb1_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
    checks++; if (cdb0_rob !== 6'b010000 || cdb1_rob !== 6'b010000 || cdb0_data !== 32'h0) begin errors++; $display("FAIL rstmid_fields: got %h/%h/%h expected 10/10/0", cdb0_rob, cdb1_rob, cdb0_data); end
`ifdef CDB_ARB_STATS_EN
    checks++; if (stall_cnt !== 64'h0) begin errors++; $display("FAIL rstmid_stall: got %h expected 0", stall_cnt); end
`endif
    req_valid = 4'b0000;
    @(negedge clock); rst_n = 1'b1;
    @(negedge clock);
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL rstmid_ready_back: got %b expected 1111", req_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checks++; if (cdb0_valid !== 1'b0 || cdb1_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard%0d: got %b/%b expected 0/0", k, cdb0_valid, cdb1_valid); end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] acc_seq [NR];
    logic [3:0] exp_seq [NR];
    int win_cnt [NR];
    int pat0 [3] = '{0, 3, 1};
    int pat1 [3] = '{1, 0, 3};
    int acc_tot = 0;
    int bc_tot = 0;
    logic v;
    logic [ROB_W-1:0] r;
    int id;
    for (int i = 0; i < NR; i++) begin acc_seq[i] = '0; exp_seq[i] = '0; win_cnt[i] = 0; end
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      if (k >= 2 && k <= 13) begin
        checks++;
        if (cdb0_valid !== 1'b1 || cdb1_valid !== 1'b1 || int'(cdb0_rob[5:4]) != pat0[(k - 2) % 3] || int'(cdb1_rob[5:4]) != pat1[(k - 2) % 3]) begin
          errors++; $display("FAIL fair_pair%0d: got (%b:%0d,%b:%0d) expected (1:%0d,1:%0d)", k - 2, cdb0_valid, cdb0_rob[5:4], cdb1_valid, cdb1_rob[5:4], pat0[(k - 2) % 3], pat1[(k - 2) % 3]);
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        v = (ch == 0) ? cdb0_valid : cdb1_valid;
        r = (ch == 0) ? cdb0_rob : cdb1_rob;
        if (v === 1'b1) begin
          id = int'(r[5:4]);
          checks++;
          if (r[3:0] !== exp_seq[id]) begin errors++; $display("FAIL fair_order: req %0d got seq %0d expected %0d", id, r[3:0], exp_seq[id]); end
          exp_seq[id] = exp_seq[id] + 4'd1;
          bc_tot++;
          if (k >= 2 && k <= 13) win_cnt[id]++;
        end
      end
      req_valid = 4'b0000;
      if (k < 12) begin
        for (int i = 0; i < NR; i++) begin
          if (i != 2) set_req(i, {2'(i), acc_seq[i]}, 32'hF000 + 32'(i * 16) + 32'(acc_seq[i]));
        end
        req_valid = 4'b1011;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin acc_seq[i] = acc_seq[i] + 4'd1; acc_tot++; end
      end
    end
    checks++; if (win_cnt[0] != 8) begin errors++; $display("FAIL fair_cnt0: got %0d expected 8", win_cnt[0]); end
    checks++; if (win_cnt[1] != 8) begin errors++; $display("FAIL fair_cnt1: got %0d expected 8", win_cnt[1]); end
    checks++; if (win_cnt[3] != 8) begin errors++; $display("FAIL fair_cnt3: got %0d expected 8", win_cnt[3]); end
    checks++; if (bc_tot != acc_tot) begin errors++; $display("FAIL fair_total: got %0d broadcasts expected %0d", bc_tot, acc_tot); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_fairness();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Shares the two common data buses (CDB0, CDB1) among the functional-unit result producers: ALU, branch/jump unit, load unit and multiply unit. Every reservation station and the ROB snoop these buses.
Each producer pushes {robNum, data} results into a private small FIFO. Each cycle, a round-robin scheduler drains up to two FIFOs onto the two registered CDB channels.
Producers never drop a result; they stall only on their own FIFO being full.

Parameters:
NUM_REQ, 4, number of result producers (requester 0 = ALU, 1 = branch, 2 = load, 3 = mul)
FIFO_DEPTH, 2, entries per requester FIFO (power of two, >= 2)
ROB_W, 6, robNum width
DATA_W, 32, result data width

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  mispredict flush; clears all pending results
req_valid  in  NUM_REQ  result offered by requester i
req_rob  in  NUM_REQ*ROB_W  packed robNum, requester i at [i*ROB_W +: ROB_W]
req_data  in  NUM_REQ*DATA_W  packed result data, same packing
req_ready  out  NUM_REQ  requester i FIFO can accept
cdb0_valid  out  1  CDB channel 0 broadcast, one-cycle pulse
cdb0_rob  out  ROB_W  channel 0 robNum
cdb0_data  out  DATA_W  channel 0 data
cdb1_valid  out  1  CDB channel 1 broadcast
cdb1_rob  out  ROB_W  channel 1 robNum
cdb1_data  out  DATA_W  channel 1 data

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values:
  - All FIFOs empty; rr_ptr = 0.
  - cdb0_valid and cdb1_valid = 0; cdb*_rob = INVALID_ROB (6'b010000); cdb*_data = 0.
  - req_ready = 0 while rst_n is low, then follows FIFO state.
- Push: req_ready[i] = !full[i], derived from registered state only, never from req_valid.
  - Push at the clock edge when req_valid[i] && req_ready[i].
  - A full FIFO does not accept, even if it pops in the same cycle.
- Per-requester order is preserved (FIFO). There is no ordering guarantee across requesters.
- Grant at each edge, over non-empty FIFOs (state before this edge's push):
  - g0 = first non-empty index scanning from rr_ptr upward, mod NUM_REQ.
  - g1 = next non-empty index after g0 in the same scan, g1 != g0.
  - g0 pops to CDB0 and g1 pops to CDB1. If only one FIFO is non-empty, CDB1 stays idle. There is at most one pop per requester per cycle.
  - rr_ptr becomes (last granted index + 1) mod NUM_REQ; it is unchanged if nothing is granted.
- Outputs are registered.
  - cdb*_valid is high for exactly one cycle per popped entry.
  - When valid is 0, cdb*_rob = INVALID_ROB; cdb*_data holds its last value.
- Latency:
  - Entry accepted at edge t into an empty FIFO: broadcast visible after edge t+1.
  - No same-cycle bypass from req to CDB.
- Throughput: 2 results per cycle aggregate; 1 per cycle per requester.
- Flush:
  - At an edge with flush = 1, all FIFOs are emptied and cdb0_valid/cdb1_valid are 0 after that edge.
  - Flush dominates push: a result offered that cycle is discarded, and the requester sees it as accepted if req_ready was 1.
  - rr_ptr is retained.
- Reset mid-operation: asynchronously discards all entries and forces the reset values immediately.
- The block does no robNum checking; duplicate robNums are broadcast as given.

Optional Feature:
CDB_ARB_STATS_EN:
- Defined: adds output stall_cnt (NUM_REQ*16 bits, requester i at [i*16 +: 16]). Each counter increments every cycle req_valid[i] && !req_ready[i].
  - Counters saturate at 16'hFFFF.
  - Cleared only by rst_n; flush does not clear them.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cdb_pkg:
  - ROB_W and DATA_W constants.
  - INVALID_ROB = 6'b010000.
  - Packed struct cdb_entry_t {rob, data}.
  - Requester index constants REQ_ALU = 0, REQ_BR = 1, REQ_LD = 2, REQ_MUL = 3.
- Sub-module cdb_req_fifo: per-requester FIFO with push/pop/flush, full/empty flags and head entry output. It is instantiated NUM_REQ times.
- The round-robin two-grant picker stays inline in cdb_arbiter.

Test Plan:
1. Reset, then req_valid = 4'b0010 with rob = 5, data = 32'h1234 at edge t -> cdb0_valid = 1, rob = 5, data = 32'h1234 after edge t+1; cdb1_valid = 0; cdb*_rob = 6'b010000 otherwise.
2. All four requesters push one entry at edge t with rob = 1,2,3,4 and rr_ptr = 0 -> edge t+1: CDB0 = rob 1, CDB1 = rob 2; edge t+2: CDB0 = rob 3, CDB1 = rob 4; rr_ptr returns to 0.
3. Requester 2 pushes 3 back-to-back while others are idle -> req_ready[2] drops to 0 only when full (FIFO_DEPTH = 2 with no pop in between); all 3 broadcast in order, one per cycle, on CDB0.
4. Fairness: requesters 0, 1 and 3 hold req_valid continuously for 12 cycles -> grant pairs rotate (0,1), (3,0), (1,3)…; each requester is granted 8 times ±1 and none starves.
5. FIFOs hold 5 entries and flush is asserted for one edge while requester 0 offers rob = 9 -> no cdb*_valid after that edge; rob 9 is never broadcast; req_ready returns to all 1.
6. rst_n pulled low mid-burst between edges -> cdb*_valid = 0 and req_ready = 0 immediately; with CDB_ARB_STATS_EN defined, stall_cnt reads 0 after reset.
